simple_alu_issue_arb: RTL

- Two-requester round-robin arbiter and 2-stage sequencer for the shared integer simple ALU in the execute stage.
- Accepts operand packets from issue slot A and slot B with valid/ready handshakes.
- Registers the granted packet onto the ALU's combinational inputs, then captures the ALU result into a writeback register with backpressure.
- Throughput: 1 op/cycle, no bubbles.

---
 rtl/simple_alu_issue_arb.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/simple_alu_issue_arb.sv
// ---------------------------------------------------------------------------
// simple_alu_issue_arb
// Two-slot round-robin arbiter and two-stage sequencer for the shared
// integer ALU. S0 (issue register) holds the granted op and drives the
// combinational ALU inputs. S1 (result register) captures the ALU result
// and presents it to writeback under a valid/ready handshake. Sustains one
// op per cycle with no bubbles.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               kills every in-flight op (no accept that cycle)
//   a_* / b_*             issue slot request packets, valid/ready handshake
//   alu_*_o               operands/opcode to the ALU, forced to 0 when S0 empty
//   alu_rd_i, alu_exc_i   combinational ALU result and exception
//   wb_*                  writeback packet (result, exc, tag, source slot)
//   busy_o                S0 or S1 holds a valid op
//   stat_*_o              accept/stall counters
//
// Build option: define SIMPLE_ALU_ARB_STATS_EN to implement the statistics
// counters; otherwise stat_*_o are tied to 0.
// ---------------------------------------------------------------------------
module simple_alu_issue_arb #(
   parameter int TAG_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             a_valid_i,
   input  logic             b_valid_i,
   output logic             a_ready_o,
   output logic             b_ready_o,
   input  logic [63:0]      a_rs1_i,
   input  logic [63:0]      b_rs1_i,
   input  logic [63:0]      a_rs2_i,
   input  logic [63:0]      b_rs2_i,
   input  logic [5:0]       a_opcode_i,
   input  logic [5:0]       b_opcode_i,
   input  logic [6:0]       a_op_func_i,
   input  logic [6:0]       b_op_func_i,
   input  logic [15:0]      a_mem_func_i,
   input  logic [15:0]      b_mem_func_i,
   input  logic [TAG_W-1:0] a_tag_i,
   input  logic [TAG_W-1:0] b_tag_i,
   output logic [63:0]      alu_rs1_o,
   output logic [63:0]      alu_rs2_o,
   output logic [5:0]       alu_opcode_o,
   output logic [6:0]       alu_op_func_o,
   output logic [15:0]      alu_mem_func_o,
   input  logic [63:0]      alu_rd_i,
   input  logic             alu_exc_i,
   output logic             wb_valid_o,
   input  logic             wb_ready_i,
   output logic [63:0]      wb_rd_o,
   output logic             wb_exc_o,
   output logic [TAG_W-1:0] wb_tag_o,
   output logic             wb_src_o,
   output logic             busy_o,
   output logic [31:0]      stat_a_o,
   output logic [31:0]      stat_b_o,
   output logic [31:0]      stat_stall_o
);

   logic             vld_p0, vld_p1;
   logic             last_b;         // 1: slot B was granted most recently
   logic [63:0]      rs1_p0, rs2_p0;
   logic [5:0]       opcode_p0;
   logic [6:0]       op_func_p0;
   logic [15:0]      mem_func_p0;
   logic [TAG_W-1:0] tag_p0;
   logic             src_p0;
   logic [63:0]      rd_p1;
   logic             exc_p1;
   logic [TAG_W-1:0] tag_p1;
   logic             src_p1;

   logic s1_load, s0_free, a_acc, b_acc, any_acc;

   assign s1_load = vld_p0 & (!vld_p1 | wb_ready_i);
   assign s0_free = !vld_p0 | s1_load;

   // Each ready looks only at the other slot's valid, so the two readies are
   // mutually exclusive whenever both slots request.
   assign a_ready_o = s0_free & !flush_i & !rst_i & (!b_valid_i | last_b);
   assign b_ready_o = s0_free & !flush_i & !rst_i & (!a_valid_i | !last_b);
   assign a_acc     = a_valid_i & a_ready_o;
   assign b_acc     = b_valid_i & b_ready_o;
   assign any_acc   = a_acc | b_acc;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         last_b <= 1'b1;
      end else if (flush_i) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         if (s1_load)         vld_p1 <= 1'b1;
         else if (wb_ready_i) vld_p1 <= 1'b0;
         if (any_acc)         vld_p0 <= 1'b1;
         else if (s1_load)    vld_p0 <= 1'b0;
         if (a_acc)           last_b <= 1'b0;
         else if (b_acc)      last_b <= 1'b1;
      end
   end

   // Stage p0: issue register, loaded from the granted slot
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rs1_p0      <= '0;
         rs2_p0      <= '0;
         opcode_p0   <= '0;
         op_func_p0  <= '0;
         mem_func_p0 <= '0;
         tag_p0      <= '0;
         src_p0      <= 1'b0;
      end else if (a_acc) begin
         rs1_p0      <= a_rs1_i;
         rs2_p0      <= a_rs2_i;
         opcode_p0   <= a_opcode_i;
         op_func_p0  <= a_op_func_i;
         mem_func_p0 <= a_mem_func_i;
         tag_p0      <= a_tag_i;
         src_p0      <= 1'b0;
      end else if (b_acc) begin
         rs1_p0      <= b_rs1_i;
         rs2_p0      <= b_rs2_i;
         opcode_p0   <= b_opcode_i;
         op_func_p0  <= b_op_func_i;
         mem_func_p0 <= b_mem_func_i;
         tag_p0      <= b_tag_i;
         src_p0      <= 1'b1;
      end
   end

   // Stage p1: result register, captures the ALU output as S0 advances
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_p1  <= '0;
         exc_p1 <= 1'b0;
         tag_p1 <= '0;
         src_p1 <= 1'b0;
      end else if (s1_load) begin
         rd_p1  <= alu_rd_i;
         exc_p1 <= alu_exc_i;
         tag_p1 <= tag_p0;
         src_p1 <= src_p0;
      end
   end

   // Payload may be stale after a flush, so outputs are gated by valid.
   assign alu_rs1_o      = vld_p0 ? rs1_p0      : '0;
   assign alu_rs2_o      = vld_p0 ? rs2_p0      : '0;
   assign alu_opcode_o   = vld_p0 ? opcode_p0   : '0;
   assign alu_op_func_o  = vld_p0 ? op_func_p0  : '0;
   assign alu_mem_func_o = vld_p0 ? mem_func_p0 : '0;

   assign wb_valid_o = vld_p1;
   assign wb_rd_o    = vld_p1 ? rd_p1  : '0;
   assign wb_exc_o   = vld_p1 & exc_p1;
   assign wb_tag_o   = vld_p1 ? tag_p1 : '0;
   assign wb_src_o   = vld_p1 & src_p1;
   assign busy_o     = vld_p0 | vld_p1;

`ifdef SIMPLE_ALU_ARB_STATS_EN
   logic [31:0] cnt_a, cnt_b, cnt_stall;

   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_a     <= '0;
         cnt_b     <= '0;
         cnt_stall <= '0;
      end else begin
         if (a_acc)                cnt_a     <= cnt_a + 32'd1;
         if (b_acc)                cnt_b     <= cnt_b + 32'd1;
         if (vld_p1 & !wb_ready_i) cnt_stall <= cnt_stall + 32'd1;
      end
   end

   assign stat_a_o     = cnt_a;
   assign stat_b_o     = cnt_b;
   assign stat_stall_o = cnt_stall;
`else
   assign stat_a_o     = '0;
   assign stat_b_o     = '0;
   assign stat_stall_o = '0;
`endif

endmodule
